prbs_gen_chk: RTL and testbench

- Parametrised, synthesisable PRBS generator plus self-synchronising checker for serial link and ring-buffer loopback testing.
- Generalises the fixed 20-bit XNOR LFSR stimulus/compare logic: programmable polynomial, lock/loss state machine, saturating error and bit counters.
- Generator and checker are independent strobe-driven halves in one clock domain. They sit at the tx and rx ends of the block under test.

---
 rtl/prbs_pkg.sv | 20 ++
 rtl/prbs_lfsr.sv | 31 +++
 rtl/prbs_gen_chk.sv | 164 ++++++++++++++++
 tb/tb_prbs_gen_chk.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// PRBS generator/checker shared definitions.
// Checker state encoding, LFSR feedback and default polynomial.
package prbs_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  localparam int DEF_LFSR_W = 20;
  localparam int DEF_TAP    = 3;

  function automatic logic prbs_fb(
    input logic lo,
    input logic hi
  );
    return lo ~^ hi;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci XNOR shift register, self-feedback or serial load.
// obit: next MSB in generator mode, predicted bit in load mode.
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int W   = DEF_LFSR_W,
  parameter int TAP = DEF_TAP
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic load,
  input  logic din,
  output logic obit
);

  logic [W-1:0] q;
  logic         fb;

  assign fb   = prbs_fb(q[TAP-1], q[W-1]);
  assign obit = load ? fb : q[W-2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], load ? din : fb};
    end
  end

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS generator plus self-synchronising lock/loss checker.
// Define PRBS_ERR_INJECT_EN to add the inject_err port.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int LFSR_W      = DEF_LFSR_W,
  parameter int TAP         = DEF_TAP,
  parameter int LOCK_CNT    = 32,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             gen_en,
  output logic             tx_data,
  input  logic             chk_valid,
  input  logic             rx_data,
  input  logic             clr_counts,
  output logic             locked,
  output logic             bit_error,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
`ifdef PRBS_ERR_INJECT_EN
  ,
  input  logic             inject_err
`endif
);

  localparam int FW = $clog2(LFSR_W + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);

  localparam logic [FW-1:0]    FILL_MAX   = FW'(LFSR_W);
  localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [BW-1:0]    WB_MAX     = BW'(WINDOW);
  localparam logic [EW-1:0]    WE_MAX     = EW'(LOSS_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic gen_nxt;
  logic expected;
  logic flip;
  logic mis;

`ifdef PRBS_ERR_INJECT_EN
  assign flip = inject_err;
`else
  assign flip = 1'b0;
`endif

  prbs_lfsr #(.W(LFSR_W), .TAP(TAP)) u_gen (
    .clock (clock),
    .reset (reset),
    .en    (gen_en),
    .load  (1'b0),
    .din   (1'b0),
    .obit  (gen_nxt)
  );

  prbs_lfsr #(.W(LFSR_W), .TAP(TAP)) u_chk (
    .clock (clock),
    .reset (reset),
    .en    (chk_valid),
    .load  (1'b1),
    .din   (rx_data),
    .obit  (expected)
  );

  assign mis = rx_data ^ expected;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_data <= 1'b0;
    end else if (gen_en) begin
      tx_data <= gen_nxt ^ flip;
    end
  end

  chk_state_e       state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [BW-1:0]    wb_q, wb_d;
  logic [EW-1:0]    we_q, we_d;
  logic [CNT_W-1:0] err_d, bit_d;
  logic             berr_d;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    match_d = match_q;
    wb_d    = wb_q;
    we_d    = we_q;
    err_d   = err_count;
    bit_d   = bit_count;
    berr_d  = 1'b0;
    if (chk_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
          end else if (mis) begin
            match_d = '0;
          end else if (match_q == MATCH_LAST) begin
            state_d = LOCKED;
            match_d = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        LOCKED: begin
          berr_d = mis;
          wb_d   = wb_q + 1'b1;
          if (bit_count != CNT_MAX) bit_d = bit_count + 1'b1;
          if (mis) begin
            we_d = we_q + 1'b1;
            if (err_count != CNT_MAX) err_d = err_count + 1'b1;
          end
          // loss wins over a window rollover on the same beat
          if (we_d == WE_MAX) begin
            state_d = SEARCH;
            fill_d  = '0;
            match_d = '0;
            wb_d    = '0;
            we_d    = '0;
          end else if (wb_d == WB_MAX) begin
            wb_d = '0;
            we_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (clr_counts) begin
      err_d = '0;
      bit_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      fill_q    <= '0;
      match_q   <= '0;
      wb_q      <= '0;
      we_q      <= '0;
      err_count <= '0;
      bit_count <= '0;
      bit_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      wb_q      <= wb_d;
      we_q      <= we_d;
      err_count <= err_d;
      bit_count <= bit_d;
      bit_error <= berr_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Self-checking bench for prbs_gen_chk: vector table, corner sequences,
// random loopback against a queue-based stream model.
module tb_prbs_gen_chk;

  localparam int W    = 20;
  localparam int TAP  = 3;
  localparam int LOCK = 32;
  localparam int WIN  = 64;
  localparam int LOSS = 8;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 0, reset = 0, gen_en = 0, chk_valid = 0;
  logic rx_data = 0, clr_counts = 0, inject_err = 0;
  logic tx_data, locked, bit_error;
  logic [CW-1:0] err_count, bit_count;

  prbs_gen_chk #(
    .LFSR_W(W), .TAP(TAP), .LOCK_CNT(LOCK),
    .WINDOW(WIN), .LOSS_THRESH(LOSS), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .gen_en(gen_en),
    .tx_data(tx_data), .chk_valid(chk_valid), .rx_data(rx_data),
    .clr_counts(clr_counts), .locked(locked), .bit_error(bit_error),
    .err_count(err_count), .bit_count(bit_count)
`ifdef PRBS_ERR_INJECT_EN
    , .inject_err(inject_err)
`endif
  );

  always #5 clock = ~clock;

  int npass = 0, ntot = 0;
  int p, k, e0;
  bit loop = 0, flip = 0;

  task automatic check(string name, longint act, longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: generator is the zero-history sequence x[n] = x[n-TAP] ~^ x[n-W];
  // the checker predicts from its own history of received bits.
  bit gs[$];
  bit rh[$];
  int gp;
  bit m_tx, m_lk, m_be;
  int m_err, m_bit, fill, match, wb, we;

  function automatic bit hb(int i);
    return (i < 0) ? 1'b0 : rh[i];
  endfunction

  task automatic model_reset();
    gs.delete();
    repeat (W) gs.push_back(1'b0);
    rh.delete();
    gp = 0; m_tx = 0; m_lk = 0; m_be = 0;
    m_err = 0; m_bit = 0; fill = 0; match = 0; wb = 0; we = 0;
  endtask

  task automatic model_step();
    int n;
    bit e, mis;
    if (gen_en) begin
      n = gs.size();
      gs.push_back(gs[n-TAP] ~^ gs[n-W]);
      gp++;
      m_tx = gs[gp] ^ inject_err;
    end
    m_be = 0;
    if (chk_valid) begin
      e = hb(rh.size() - TAP) ~^ hb(rh.size() - W);
      mis = rx_data ^ e;
      rh.push_back(rx_data);
      if (!m_lk) begin
        if (fill < W) fill++;
        else if (mis) match = 0;
        else begin
          match++;
          if (match == LOCK) begin m_lk = 1; match = 0; end
        end
      end else begin
        if (m_bit < CMAX) m_bit++;
        wb++;
        if (mis) begin
          m_be = 1; we++;
          if (m_err < CMAX) m_err++;
        end
        if (we == LOSS) begin
          m_lk = 0; fill = 0; match = 0; wb = 0; we = 0;
        end else if (wb == WIN) begin
          wb = 0; we = 0;
        end
      end
    end
    if (clr_counts) begin m_err = 0; m_bit = 0; end
  endtask

  task automatic cyc();
    if (loop) rx_data = tx_data ^ flip;
    model_step();
    @(posedge clock);
    #1;
    check("tx_data", tx_data, m_tx);
    check("locked", locked, m_lk);
    check("bit_error", bit_error, m_be);
    check("err_count", err_count, m_err);
    check("bit_count", bit_count, m_bit);
  endtask

  task automatic do_reset();
    #2 reset = 0;
    #1;
    check("rst_tx", tx_data, 0);
    check("rst_locked", locked, 0);
    check("rst_berr", bit_error, 0);
    check("rst_err", err_count, 0);
    check("rst_bit", bit_count, 0);
    model_reset();
    #1 reset = 1;
  endtask

  task automatic lock_run(string tag);
    for (int i = 1; i <= W + LOCK; i++) begin
      cyc();
      if (i == W + LOCK - 1) check({tag, "_pre"}, locked, 0);
      if (i == W + LOCK) check({tag, "_lock"}, locked, 1);
    end
  endtask

  typedef struct {
    bit gen;
    int n;
    bit tx;
  } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{1, 19, 0};
    tbl[1] = '{1, 1, 1};
    tbl[2] = '{0, 10, 1};
    tbl[3] = '{1, 2, 1};
    tbl[4] = '{1, 1, 0};

    model_reset();
    #3;
    check("init_tx", tx_data, 0);
    check("init_locked", locked, 0);
    #4 reset = 1;
    @(posedge clock);
    #1;

    foreach (tbl[i]) begin
      gen_en = tbl[i].gen;
      repeat (tbl[i].n) begin
        cyc();
        check("tbl_tx", tx_data, tbl[i].tx);
      end
    end

    gen_en = 0;
    do_reset();
    gen_en = 1; chk_valid = 1; loop = 1;
    lock_run("lock");
    repeat (30) cyc();
    check("since_lock", bit_count, 30);
    check("no_err", err_count, 0);

    flip = 1; cyc(); flip = 0;
    p = bit_error;
    repeat (40) begin cyc(); p += bit_error; end
    check("triple_pulses", p, 3);
    check("triple_err", err_count, 3);
    check("triple_lock", locked, 1);

    flip = 1; clr_counts = 1; cyc(); flip = 0; clr_counts = 0;
    check("clr_err", err_count, 0);
    repeat (30) cyc();
    check("clr_echo", err_count, 2);

    clr_counts = 1; cyc(); clr_counts = 0;
    repeat (70) cyc();
    check("bit_sat", bit_count, CMAX);

    loop = 0; rx_data = 1;
    repeat (64) cyc();
    loop = 1; k = 0;
    while (!locked && k < 200) begin cyc(); k++; end
    check("relock_any", locked, 1);

    loop = 0; rx_data = 0; k = 0;
    while (locked && k < 64) begin cyc(); k++; end
    check("loss", locked, 0);
    e0 = err_count;
    loop = 1;
    lock_run("relock");
    check("err_frozen", err_count, e0);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      gen_en = ($urandom_range(0, 7) != 0);
      chk_valid = (i % 700 < 600) ? gen_en : 1'($urandom);
      loop = ((i % 500) >= 40);
      if (!loop) rx_data = 1'($urandom);
      flip = ($urandom_range(0, 99) == 0);
      clr_counts = ($urandom_range(0, 199) == 0);
`ifdef PRBS_ERR_INJECT_EN
      inject_err = ($urandom_range(0, 149) == 0);
`endif
      cyc();
    end
    flip = 0; clr_counts = 0; inject_err = 0;

    gen_en = 1; chk_valid = 1; loop = 1;
    do_reset();
    lock_run("lock2");
`ifdef PRBS_ERR_INJECT_EN
    inject_err = 1; cyc(); inject_err = 0;
    p = bit_error;
    repeat (45) begin cyc(); p += bit_error; end
    check("inj_pulses", p, 3);
    check("inj_err", err_count, 3);
    check("inj_lock", locked, 1);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
